// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM adapter port between the CPU path (fixed
// priority) and a DMA engine. DMA is protected by a starvation counter and may
// hold a bounded burst lock. A watchdog converts a missing m_ack into an error
// response so neither requester can hang.
module sdram_arbiter #(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned BURST_MAX = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              resetb,
    // CPU requester (index 0)
    input  logic              cpu_req,
    input  logic              cpu_rwb,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    // DMA requester (index 1)
    input  logic              dma_req,
    input  logic              dma_rwb,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    input  logic              dma_lock,
    output logic [7:0]        dma_rdata,
    output logic              dma_ack,
    output logic              dma_err,
    // Adapter side
    output logic              m_req,
    output logic              m_rwb,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata,
    input  logic              m_ack,
    // Status
    output logic              o_owner,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAX_WAIT  = 4'(MAX_WAIT);
    localparam logic [7:0] LP_BURST_MAX = 8'(BURST_MAX);
    localparam logic [7:0] LP_TO_LAST   = 8'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_grant_cpu;
    logic                w_grant_dma;
    logic                w_done;

    logic                r_m_req;
    logic                r_m_rwb;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [7:0]          r_m_wdata;
    logic                r_owner;
    logic                r_busy;
    logic [7:0]          r_cpu_rdata;
    logic                r_cpu_ack;
    logic                r_cpu_err;
    logic [7:0]          r_dma_rdata;
    logic                r_dma_ack;
    logic                r_dma_err;
    logic [7:0]          r_to_cnt;
    logic [3:0]          r_wait_cnt;
    logic [7:0]          r_burst_cnt;
    logic                r_lock_active;

    // Next-state and grant decode; every output of this block is defaulted first.
    always_comb begin
        // NOTE: assigning defaults before the case keeps this block free of inferred latches.
        w_next_state = r_state;
        w_grant_cpu  = 1'b0;
        w_grant_dma  = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dma_req && (!cpu_req ||
                                (r_lock_active && (r_burst_cnt < LP_BURST_MAX)) ||
                                (r_wait_cnt == LP_MAX_WAIT))) begin
                    w_grant_dma  = 1'b1;
                    w_next_state = ST_BUSY;
                end else if (cpu_req) begin
                    w_grant_cpu  = 1'b1;
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (m_ack || (r_to_cnt == LP_TO_LAST)) begin
                    w_done       = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetb) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetb) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // Adapter request, latched payload, owner and busy flag.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_m_req   <= 1'b0;
            r_m_rwb   <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_owner   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
            if (w_grant_dma) begin
                r_m_req   <= 1'b1;
                r_m_rwb   <= dma_rwb;
                r_m_addr  <= dma_addr;
                r_m_wdata <= dma_wdata;
                r_owner   <= 1'b1;
            end else if (w_grant_cpu) begin
                r_m_req   <= 1'b1;
                r_m_rwb   <= cpu_rwb;
                r_m_addr  <= cpu_addr;
                r_m_wdata <= cpu_wdata;
                r_owner   <= 1'b0;
            end else if (w_done) begin
                r_m_req   <= 1'b0;
            end
        end
    end

    // Watchdog: counts BUSY cycles since the grant.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)                     r_to_cnt <= '0;
        else if (w_grant_cpu || w_grant_dma) r_to_cnt <= '0;
        else if (r_state == ST_BUSY)     r_to_cnt <= r_to_cnt + 8'd1;
    end

    // Response capture: one-cycle ack to the owner, rdata/err held until its next response.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_cpu_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_dma_rdata <= '0;
            r_dma_ack   <= 1'b0;
            r_dma_err   <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_dma_ack <= 1'b0;
            if (w_done) begin
                if (r_owner) begin
                    r_dma_ack   <= 1'b1;
                    r_dma_err   <= !m_ack;
                    r_dma_rdata <= m_ack ? m_rdata : 8'hFF;
                end else begin
                    r_cpu_ack   <= 1'b1;
                    r_cpu_err   <= !m_ack;
                    r_cpu_rdata <= m_ack ? m_rdata : 8'hFF;
                end
            end
        end
    end

    // Fairness state: DMA starvation counter, burst lock and burst length.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_wait_cnt    <= '0;
            r_burst_cnt   <= '0;
            r_lock_active <= 1'b0;
        end else begin
            if (w_grant_dma) begin
                r_wait_cnt <= '0;
            end else if (w_grant_cpu && dma_req && (r_wait_cnt < LP_MAX_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end

            if (w_grant_cpu) begin
                r_burst_cnt <= '0;
            end else if (w_grant_dma) begin
                if (!r_lock_active)                  r_burst_cnt <= '0;
                else if (r_burst_cnt < LP_BURST_MAX) r_burst_cnt <= r_burst_cnt + 8'd1;
            end

            if (r_state == ST_RESP)                  r_lock_active <= r_owner && dma_lock;
            else if ((r_state == ST_IDLE) && !dma_req) r_lock_active <= 1'b0;
        end
    end

    assign m_req     = r_m_req;
    assign m_rwb     = r_m_rwb;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_err   = r_cpu_err;
    assign dma_rdata = r_dma_rdata;
    assign dma_ack   = r_dma_ack;
    assign dma_err   = r_dma_err;
    assign o_owner   = r_owner;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: inputs are driven and outputs sampled on
// the falling clock edge; expected values are hand-computed constants.
module tb_sdram_arbiter;

    localparam int ADDR_W = 24;

    logic              clk = 1'b0;
    logic              resetb;
    logic              cpu_req, cpu_rwb, dma_req, dma_rwb, dma_lock;
    logic [ADDR_W-1:0] cpu_addr, dma_addr;
    logic [7:0]        cpu_wdata, dma_wdata;
    logic [7:0]        cpu_rdata, dma_rdata;
    logic              cpu_ack, cpu_err, dma_ack, dma_err;
    logic              m_req, m_rwb, m_ack;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_wdata, m_rdata;
    logic              o_owner, o_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .ADDR_W   (24),
        .MAX_WAIT (4),
        .BURST_MAX(8),
        .TIMEOUT  (255)
    ) dut (
        .clk      (clk),
        .resetb   (resetb),
        .cpu_req  (cpu_req),
        .cpu_rwb  (cpu_rwb),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ack  (cpu_ack),
        .cpu_err  (cpu_err),
        .dma_req  (dma_req),
        .dma_rwb  (dma_rwb),
        .dma_addr (dma_addr),
        .dma_wdata(dma_wdata),
        .dma_lock (dma_lock),
        .dma_rdata(dma_rdata),
        .dma_ack  (dma_ack),
        .dma_err  (dma_err),
        .m_req    (m_req),
        .m_rwb    (m_rwb),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack),
        .o_owner  (o_owner),
        .o_busy   (o_busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a grant, check the owner, ack at once with rd and check the response.
    task automatic serve(input logic exp_owner, input logic [7:0] rd, input string tag, input bit drop);
        int n = 0;
        while (m_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_grant"}, 32'(m_req), 32'd1);
        check({tag, "_owner"}, 32'(o_owner), 32'(exp_owner));
        m_ack   = 1'b1;
        m_rdata = rd;
        tick();
        m_ack   = 1'b0;
        check({tag, "_acks"}, 32'({cpu_ack, dma_ack}), exp_owner ? 32'd1 : 32'd2);
        check({tag, "_rdata"}, exp_owner ? 32'(dma_rdata) : 32'(cpu_rdata), 32'(rd));
        if (drop) begin
            cpu_req = 1'b0;
            dma_req = 1'b0;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        int  cnt;
        bit  seen;
        resetb = 1'b0;
        cpu_req = 1'b0; cpu_rwb = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_rwb = 1'b0; dma_addr = '0; dma_wdata = '0; dma_lock = 1'b0;
        m_ack = 1'b0; m_rdata = '0;
        cnt = 0; seen = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_flags", 32'({m_req, m_rwb, cpu_ack, dma_ack, cpu_err, dma_err, o_owner, o_busy}), 32'd0);
        check("rst_addr",  32'(m_addr), 32'd0);
        check("rst_data",  32'({m_wdata, cpu_rdata, dma_rdata}), 32'd0);
        resetb = 1'b1;
        tick();

        // CPU read alone, adapter acks two cycles after m_req with 8'h5A
        cpu_req = 1'b1; cpu_rwb = 1'b1; cpu_addr = 24'h000010;
        tick();
        check("t1_mreq",  32'(m_req), 32'd1);
        check("t1_addr",  32'(m_addr), 32'h10);
        check("t1_rwb",   32'(m_rwb), 32'd1);
        check("t1_owner", 32'(o_owner), 32'd0);
        check("t1_busy",  32'(o_busy), 32'd1);
        check("t1_early", 32'(cpu_ack), 32'd0);
        tick();
        check("t1_hold",  32'({m_req, cpu_ack}), 32'd2);
        m_ack = 1'b1; m_rdata = 8'h5A;
        tick();
        m_ack = 1'b0; cpu_req = 1'b0;
        check("t1_ack",   32'({cpu_ack, cpu_err, dma_ack}), 32'd4);
        check("t1_rdata", 32'(cpu_rdata), 32'h5A);
        check("t1_mdrop", 32'(m_req), 32'd0);
        tick();
        check("t1_idle",  32'({o_busy, cpu_ack, dma_ack}), 32'd0);
        check("t1_hold_rdata", 32'(cpu_rdata), 32'h5A);

        // Both requesting, no lock: C,C,C,C,D,C,C,C,C,D
        cpu_req = 1'b1; dma_req = 1'b1; dma_rwb = 1'b1; dma_addr = 24'h000200;
        for (int i = 0; i < 10; i++) begin
            serve((i == 4) || (i == 9), 8'(8'h10 + i), $sformatf("t2_g%0d", i), i == 9);
            if ((i == 4) || (i == 9)) check($sformatf("t2_wait%0d", i), 32'(dut.r_wait_cnt), 32'd0);
        end

        // Locked DMA burst with CPU requesting throughout: C x4, D, D x8, C
        tick();
        dma_lock = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
        for (int i = 0; i < 14; i++) begin
            serve((i >= 4) && (i <= 12), 8'(8'h40 + i), $sformatf("t3_g%0d", i), i == 13);
        end
        dma_lock = 1'b0;

        // Adapter never acks: 255 cycles of m_req, then err response
        tick();
        cpu_req = 1'b1; cpu_rwb = 1'b1; cpu_addr = 24'hABCDEF;
        for (int k = 0; k < 400 && !seen; k++) begin
            tick();
            if (m_req === 1'b1) cnt++;
            if (cpu_ack === 1'b1) seen = 1'b1;
        end
        cpu_req = 1'b0;
        check("t4_mreq_cycles", 32'(cnt), 32'd255);
        check("t4_ack_err", 32'({cpu_ack, cpu_err, dma_ack, m_req}), 32'hC);
        check("t4_rdata",   32'(cpu_rdata), 32'hFF);
        check("t4_dma_hold", 32'(dma_rdata), 32'h4C);
        tick();
        check("t4_idle", 32'({o_busy, cpu_ack}), 32'd0);

        // Reset pulsed while BUSY
        tick();
        cpu_req = 1'b1; cpu_rwb = 1'b0; cpu_wdata = 8'h77; cpu_addr = 24'h000033;
        tick();
        check("t5_busy", 32'({m_req, o_busy}), 32'd3);
        #1 resetb = 1'b0;
        #1;
        check("t5_rst_flags", 32'({m_req, m_rwb, cpu_ack, dma_ack, cpu_err, dma_err, o_owner, o_busy}), 32'd0);
        check("t5_rst_data",  32'({m_wdata, cpu_rdata, dma_rdata}), 32'd0);
        check("t5_rst_addr",  32'(m_addr), 32'd0);
        cpu_req = 1'b0;
        tick(); tick();
        resetb = 1'b1; m_ack = 1'b1; m_rdata = 8'h99;
        tick();
        m_ack = 1'b0;
        check("t5_late_ack", 32'({cpu_ack, dma_ack, m_req, o_busy}), 32'd0);
        tick();
        check("t5_late_ack2", 32'({cpu_ack, dma_ack, m_req, o_busy}), 32'd0);
        cpu_req = 1'b1; cpu_rwb = 1'b1; cpu_addr = 24'h000044;
        serve(1'b0, 8'h66, "t5_after", 1'b1);
        check("t5_after_err", 32'(cpu_err), 32'd0);

        // DMA write: payload stable across BUSY, owner = DMA
        tick();
        dma_req = 1'b1; dma_rwb = 1'b0; dma_addr = 24'h123456; dma_wdata = 8'hA5;
        tick();
        check("t6_owner", 32'(o_owner), 32'd1);
        dma_addr = 24'h000000; dma_wdata = 8'h00; dma_rwb = 1'b1;
        cpu_addr = 24'hFFFFFF; cpu_wdata = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t6_addr%0d", k), 32'(m_addr), 32'h123456);
            check($sformatf("t6_ctl%0d", k), 32'({m_req, m_rwb, m_wdata}), 32'h2A5);
            if (k < 3) tick();
        end
        m_ack = 1'b1; m_rdata = 8'h3C;
        tick();
        m_ack = 1'b0; dma_req = 1'b0;
        check("t6_ack",   32'({dma_ack, dma_err, cpu_ack, o_owner}), 32'h9);
        check("t6_rdata", 32'(dma_rdata), 32'h3C);
        tick();
        check("t6_idle",  32'({o_busy, dma_ack}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-requester arbiter for the single SDRAM adapter port. It shares the port between the CPU bus path (requester 0) and a DMA engine (requester 1), which would otherwise each need the adapter exclusively. CPU has fixed priority. DMA is protected by a starvation counter and may hold a bounded burst lock. A watchdog turns a missing memory acknowledge into an error response, so neither requester hangs.

## Interface
- ADDR_W, 24: address width on all ports.
- MAX_WAIT, 4: consecutive CPU grants made while DMA waits before DMA is forced through (1..15).
- BURST_MAX, 8: maximum consecutive locked DMA grants (1..255).
- TIMEOUT, 255: BUSY cycles without m_ack before abort (1..255).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- resetb  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU transaction request; held with payload until cpu_ack.
- cpu_rwb  in  1  1 = read, 0 = write.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data; valid while cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  qualifies cpu_ack: 1 = timed out.
- dma_req, dma_rwb, dma_addr, dma_wdata  in  1/1/ADDR_W/8  as for CPU.
- dma_lock  in  1  request to keep ownership for the next DMA transaction.
- dma_rdata, dma_ack, dma_err  out  8/1/1  as for CPU.
- m_req  out  1  request to the adapter; held until m_ack.
- m_rwb, m_addr, m_wdata  out  1/ADDR_W/8  registered payload of the granted requester.
- m_rdata  in  8  adapter read data; valid with m_ack.
- m_ack  in  1  adapter completion, one cycle.
- o_owner  out  1  0 = CPU, 1 = DMA; last granted requester.
- o_busy  out  1  1 in BUSY or RESP.

## Operation
- The FSM has three states: IDLE, BUSY and RESP.
- **IDLE.** Each edge, the arbiter evaluates the requests.
  - Neither requesting: stay in IDLE.
  - One requesting: grant that requester.
  - Both requesting, priority order:
    1. Locked DMA (lock_active and burst_cnt < BURST_MAX) wins.
    2. Otherwise, wait_cnt == MAX_WAIT gives DMA the grant.
    3. Otherwise, CPU wins.
  - On a grant: latch the payload into m_*, set o_owner, then go to BUSY.
- **BUSY.** Behaviour while a transaction is outstanding:
  - m_req = 1 and payload stable.
  - to_cnt increments each cycle.
  - m_ack = 1: capture m_rdata into the owner's rdata, err = 0, go to RESP.
  - to_cnt reaches TIMEOUT first: drop m_req, rdata = 8'hFF, err = 1, go to RESP.
- **RESP.** The owner's ack is 1 for exactly this cycle, then the FSM returns to IDLE.
  - The non-owner's ack is never asserted.
  - rdata and err hold until the next RESP for that requester.
- **wait_cnt (4 bits):**
  - +1 on each CPU grant made while dma_req = 1, saturating at MAX_WAIT.
  - Cleared on every DMA grant.
- **Lock:**
  - lock_active is set in RESP when owner = DMA and dma_lock = 1; it is cleared otherwise.
  - burst_cnt +1 on each DMA grant made while lock_active = 1.
  - burst_cnt clears to 0 on any CPU grant, or when lock_active is 0 at a DMA grant.
  - Once burst_cnt == BURST_MAX, the lock is ignored until a CPU grant clears the count.
  - If DMA does not request in IDLE, lock_active clears.
- **Writes:** m_rdata is ignored and rdata still updates to the captured value. Requesters ignore rdata on writes.
- **Requester rule:** after seeing ack, a requester either deasserts req or presents a new payload by the following edge. The mandatory IDLE cycle guarantees a stale req is never re-granted.
- **m_ack outside BUSY** is ignored.

## Timing
- Reset values (asynchronous, taking effect immediately):
  - state = IDLE.
  - m_req, m_rwb, m_addr, m_wdata = 0.
  - cpu_rdata, dma_rdata, cpu_ack, dma_ack, cpu_err, dma_err = 0.
  - o_owner = 0, o_busy = 0.
  - All counters and lock_active = 0.
- Reset mid-transaction:
  - m_req drops in the same cycle.
  - No ack is produced for the aborted transaction.
  - The adapter's late m_ack is ignored.
- Grant edge E0 (IDLE, req sampled): m_req goes high in the cycle after E0.
- Memory ack sampled at edge E0+n (n ≥ 1): ack is high for the cycle after E0+n.
- Minimum req-to-ack: 2 edges.
- Back-to-back transactions: ack → IDLE → next grant. The minimum period is 3 cycles plus memory latency.
- Timeout: m_req is high for TIMEOUT cycles, then ack/err in the next cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- CPU read alone, adapter acks 2 cycles after m_req with 8'h5A → cpu_ack pulses once with cpu_rdata = 8'h5A and cpu_err = 0; dma_ack stays 0.
- CPU and DMA request continuously, MAX_WAIT = 4, no lock → grant sequence is C,C,C,C,D,C,C,C,C,D; wait_cnt is 0 after each D grant.
- dma_lock held, BURST_MAX = 8, CPU requesting throughout → after the first DMA grant, exactly 8 further DMA grants, then a CPU grant.
- Adapter never acks, TIMEOUT = 255 → m_req is high for exactly 255 cycles, then the owner sees ack with err = 1 and rdata = 8'hFF; the FSM is back in IDLE one cycle later.
- resetb pulsed low while in BUSY → all outputs are 0 immediately; a late m_ack produces no ack; the next cpu_req is served normally.
- DMA write to 24'h123456 with data 8'hA5 → m_addr = 24'h123456, m_wdata = 8'hA5 and m_rwb = 0, all stable for the whole BUSY period; o_owner = 1.
